// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - requester-side tag SRAM controller: init sweep, lookup/compare, refill writes
//
// Purpose: after reset, invalidates every set of the per-way tag array. It then
// serves set lookups (tag compare, hit-way and victim-way selection) and
// refill tag writes. A refill takes priority over a lookup in the same cycle.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   init_done                      invalidation sweep finished
//   lkp_valid/ready/set/tag        lookup request channel
//   rsp_valid/ready/hit/way/victim lookup result channel (one-hot way vectors)
//   fill_valid/ready/set/way/tag   refill tag-write request channel
//   tag_read_valid/ready/set       tag array read request
//   tag_read_rsp                   per-way entries, valid one cycle after the read handshake
//   tag_write_valid/ready/set/way_en/data  tag array write request
module tag_lookup_ctrl #(
  parameter int WAY_NUM   = 4,
  parameter int SET_WIDTH = 6,
  parameter int TAG_WIDTH = 20
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic                                init_done,
  input  logic                                lkp_valid,
  output logic                                lkp_ready,
  input  logic [SET_WIDTH-1:0]                lkp_set,
  input  logic [TAG_WIDTH-2:0]                lkp_tag,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic                                rsp_hit,
  output logic [WAY_NUM-1:0]                  rsp_way,
  output logic [WAY_NUM-1:0]                  rsp_victim,
  input  logic                                fill_valid,
  output logic                                fill_ready,
  input  logic [SET_WIDTH-1:0]                fill_set,
  input  logic [WAY_NUM-1:0]                  fill_way,
  input  logic [TAG_WIDTH-2:0]                fill_tag,
  output logic                                tag_read_valid,
  input  logic                                tag_read_ready,
  output logic [SET_WIDTH-1:0]                tag_read_set,
  input  logic [WAY_NUM-1:0][TAG_WIDTH-1:0]   tag_read_rsp,
  output logic                                tag_write_valid,
  input  logic                                tag_write_ready,
  output logic [SET_WIDTH-1:0]                tag_write_set,
  output logic [WAY_NUM-1:0]                  tag_write_way_en,
  output logic [TAG_WIDTH-1:0]                tag_write_data
);

  typedef enum logic [1:0] {INIT, IDLE, CMP, RESP} state_t;

  localparam logic [WAY_NUM-1:0]   WAY_ONE = {{(WAY_NUM-1){1'b0}}, 1'b1};
  localparam logic [SET_WIDTH-1:0] SET_ONE = {{(SET_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_next;
  logic [SET_WIDTH-1:0] sweep_cnt;
  logic [WAY_NUM-1:0]   rr_ptr;
  logic [TAG_WIDTH-2:0] tag_q;
  // Held response was a miss with every way valid; the pointer advances only
  // when such a response is consumed.
  logic                 rsp_full;

  logic [WAY_NUM-1:0]   way_valid;
  logic [WAY_NUM-1:0]   way_hit;
  logic [WAY_NUM-1:0]   hit_sel;
  logic [WAY_NUM-1:0]   way_inv;
  logic [WAY_NUM-1:0]   inv_sel;
  logic [WAY_NUM-1:0]   victim_sel;

  // Compare against the read data that arrives during CMP.
  always_comb begin
    way_valid = '0;
    way_hit   = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      way_valid[i] = tag_read_rsp[i][TAG_WIDTH-1];
      way_hit[i]   = tag_read_rsp[i][TAG_WIDTH-1] &&
                     (tag_read_rsp[i][TAG_WIDTH-2:0] == tag_q);
    end
  end

  // x & -x isolates the lowest set bit, i.e. the lowest-index candidate way.
  always_comb begin
    way_inv    = ~way_valid;
    hit_sel    = way_hit & (~way_hit + WAY_ONE);
    inv_sel    = way_inv & (~way_inv + WAY_ONE);
    victim_sel = (|way_inv) ? inv_sel : rr_ptr;
  end

  always_comb begin
    state_next       = state;
    lkp_ready        = 1'b0;
    fill_ready       = 1'b0;
    tag_read_valid   = 1'b0;
    tag_read_set     = lkp_set;
    tag_write_valid  = 1'b0;
    tag_write_set    = fill_set;
    tag_write_way_en = fill_way;
    tag_write_data   = {1'b1, fill_tag};
    case (state)
      INIT: begin
        tag_write_valid  = 1'b1;
        tag_write_set    = sweep_cnt;
        tag_write_way_en = '1;
        tag_write_data   = '0;
        if (tag_write_ready && (sweep_cnt == '1)) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (fill_valid) begin
          tag_write_valid = 1'b1;
          fill_ready      = tag_write_ready;
        end else begin
          tag_read_valid = lkp_valid;
          lkp_ready      = tag_read_ready;
          if (lkp_valid && tag_read_ready) begin
            state_next = CMP;
          end
        end
      end
      CMP: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      init_done  <= 1'b0;
      rr_ptr     <= WAY_ONE;
      tag_q      <= '0;
      rsp_full   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_victim <= '0;
    end else begin
      state <= state_next;
      case (state)
        INIT: begin
          if (tag_write_ready) begin
            sweep_cnt <= sweep_cnt + SET_ONE;
            if (sweep_cnt == '1) begin
              init_done <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (!fill_valid && lkp_valid && tag_read_ready) begin
            tag_q <= lkp_tag;
          end
        end
        CMP: begin
          rsp_valid  <= 1'b1;
          rsp_hit    <= |way_hit;
          rsp_way    <= hit_sel;
          rsp_victim <= (|way_hit) ? '0 : victim_sel;
          rsp_full   <= !(|way_hit) && (&way_valid);
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_full) begin
              rr_ptr <= {rr_ptr[WAY_NUM-2:0], rr_ptr[WAY_NUM-1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - directed table-driven bench for tag_lookup_ctrl
module tb_tag_lookup_ctrl;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  init_done;
  logic                  lkp_valid;
  logic                  lkp_ready;
  logic [5:0]            lkp_set;
  logic [18:0]           lkp_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_hit;
  logic [3:0]            rsp_way;
  logic [3:0]            rsp_victim;
  logic                  fill_valid;
  logic                  fill_ready;
  logic [5:0]            fill_set;
  logic [3:0]            fill_way;
  logic [18:0]           fill_tag;
  logic                  tag_read_valid;
  logic                  tag_read_ready;
  logic [5:0]            tag_read_set;
  logic [3:0][19:0]      tag_read_rsp;
  logic                  tag_write_valid;
  logic                  tag_write_ready;
  logic [5:0]            tag_write_set;
  logic [3:0]            tag_write_way_en;
  logic [19:0]           tag_write_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tag_lookup_ctrl #(.WAY_NUM(4), .SET_WIDTH(6), .TAG_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_set(lkp_set), .lkp_tag(lkp_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_victim(rsp_victim),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set),
    .fill_way(fill_way), .fill_tag(fill_tag),
    .tag_read_valid(tag_read_valid), .tag_read_ready(tag_read_ready),
    .tag_read_set(tag_read_set), .tag_read_rsp(tag_read_rsp),
    .tag_write_valid(tag_write_valid), .tag_write_ready(tag_write_ready),
    .tag_write_set(tag_write_set), .tag_write_way_en(tag_write_way_en),
    .tag_write_data(tag_write_data)
  );

  // Tag array model; starts full of valid garbage so the sweep matters.
  logic [19:0] mem [64][4];

  initial begin
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++)
        mem[s][w] = 20'hFFFFF;
    tag_read_rsp = '0;
  end

  always @(posedge clk) begin
    if (tag_write_valid && tag_write_ready)
      for (int w = 0; w < 4; w++)
        if (tag_write_way_en[w]) mem[tag_write_set][w] <= tag_write_data;
    if (tag_read_valid && tag_read_ready)
      for (int w = 0; w < 4; w++)
        tag_read_rsp[w] <= mem[tag_read_set][w];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts and ends just after a rising edge.
  task automatic do_fill(input logic [5:0] s, input logic [3:0] w, input logic [18:0] t);
    int n;
    fill_valid = 1'b1; fill_set = s; fill_way = w; fill_tag = t;
    n = 0;
    @(negedge clk);
    while (!fill_ready && n < 50) begin @(negedge clk); n++; end
    check("fill_accept", {31'd0, fill_ready}, 32'd1);
    check("fill_no_read", {31'd0, tag_read_valid}, 32'd0);
    check("fill_set", {26'd0, tag_write_set}, {26'd0, s});
    check("fill_way_en", {28'd0, tag_write_way_en}, {28'd0, w});
    check("fill_data", {12'd0, tag_write_data}, {12'd0, 1'b1, t});
    @(posedge clk); #1;
    fill_valid = 1'b0;
  endtask

  // Starts just after a rising edge; returns on the falling edge where rsp_valid is seen.
  task automatic do_lookup(input logic [5:0] s, input logic [18:0] t,
                           output logic h, output logic [3:0] w, output logic [3:0] v,
                           output int lat);
    int n;
    lkp_valid = 1'b1; lkp_set = s; lkp_tag = t;
    n = 0;
    @(negedge clk);
    while (!lkp_ready && n < 50) begin @(negedge clk); n++; end
    check("lkp_accept", {31'd0, lkp_ready}, 32'd1);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    h = rsp_hit; w = rsp_way; v = rsp_victim;
  endtask

  typedef struct {
    bit         is_lkp;
    logic [5:0] set;
    logic [3:0] way;
    logic [18:0] tag;
    logic       hit;
    logic [3:0] exp_way;
    logic [3:0] exp_vic;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic       h;
    logic [3:0] w, v;
    int         lat;
    int         sweep_bad;

    vecs[0]  = '{1'b1, 6'd3, 4'b0000, 19'h01234, 1'b0, 4'b0000, 4'b0001};
    vecs[1]  = '{1'b0, 6'd5, 4'b0100, 19'h01234, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b1, 6'd5, 4'b0000, 19'h01234, 1'b1, 4'b0100, 4'b0000};
    vecs[3]  = '{1'b1, 6'd5, 4'b0000, 19'h01235, 1'b0, 4'b0000, 4'b0001};
    vecs[4]  = '{1'b0, 6'd7, 4'b0001, 19'h00010, 1'b0, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b0, 6'd7, 4'b0010, 19'h00011, 1'b0, 4'b0000, 4'b0000};
    vecs[6]  = '{1'b0, 6'd7, 4'b0100, 19'h00012, 1'b0, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b0, 6'd7, 4'b1000, 19'h00013, 1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{1'b1, 6'd7, 4'b0000, 19'h00099, 1'b0, 4'b0000, 4'b0001};
    vecs[9]  = '{1'b1, 6'd7, 4'b0000, 19'h0AAAA, 1'b0, 4'b0000, 4'b0010};
    vecs[10] = '{1'b1, 6'd7, 4'b0000, 19'h0009A, 1'b0, 4'b0000, 4'b0100};
    vecs[11] = '{1'b1, 6'd7, 4'b0000, 19'h00012, 1'b1, 4'b0100, 4'b0000};
    vecs[12] = '{1'b1, 6'd7, 4'b0000, 19'h00055, 1'b0, 4'b0000, 4'b1000};
    vecs[13] = '{1'b1, 6'd7, 4'b0000, 19'h00056, 1'b0, 4'b0000, 4'b0001};
    vecs[14] = '{1'b0, 6'd9, 4'b0000, 19'h00005, 1'b0, 4'b0000, 4'b0000};
    vecs[15] = '{1'b1, 6'd9, 4'b0000, 19'h00005, 1'b0, 4'b0000, 4'b0001};
    vecs[16] = '{1'b0, 6'd9, 4'b0001, 19'h00077, 1'b0, 4'b0000, 4'b0000};
    vecs[17] = '{1'b0, 6'd9, 4'b0010, 19'h00077, 1'b0, 4'b0000, 4'b0000};
    vecs[18] = '{1'b1, 6'd9, 4'b0000, 19'h00077, 1'b1, 4'b0001, 4'b0000};
    vecs[19] = '{1'b1, 6'd9, 4'b0000, 19'h00078, 1'b0, 4'b0000, 4'b0100};
    vecs[20] = '{1'b1, 6'd3, 4'b0000, 19'h00000, 1'b0, 4'b0000, 4'b0001};

    rst_n = 1'b0;
    lkp_valid = 1'b0; lkp_set = '0; lkp_tag = '0;
    fill_valid = 1'b0; fill_set = '0; fill_way = '0; fill_tag = '0;
    rsp_ready = 1'b1; tag_read_ready = 1'b1; tag_write_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    check("rst_rsp_way", {28'd0, rsp_way}, 32'd0);
    check("rst_rsp_victim", {28'd0, rsp_victim}, 32'd0);
    check("rst_sweep_set", {26'd0, tag_write_set}, 32'd0);

    // Sweep, with a lookup pending that must not be issued
    lkp_valid = 1'b1; lkp_set = 6'd1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("sweep_set", {26'd0, tag_write_set}, i);
      if (!(tag_write_valid && tag_write_way_en == 4'hF && tag_write_data == 20'd0 &&
            !tag_read_valid && !lkp_ready && !fill_ready && !init_done))
        sweep_bad++;
      if (i == 63) lkp_valid = 1'b0;
    end
    check("sweep_ctrl", sweep_bad, 32'd0);
    @(negedge clk);
    check("init_done", {31'd0, init_done}, 32'd1);
    check("idle_no_write", {31'd0, tag_write_valid}, 32'd0);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].is_lkp) begin
        do_lookup(vecs[i].set, vecs[i].tag, h, w, v, lat);
        check($sformatf("v%0d_latency", i), lat, 32'd2);
        check($sformatf("v%0d_hit", i), {31'd0, h}, {31'd0, vecs[i].hit});
        check($sformatf("v%0d_way", i), {28'd0, w}, {28'd0, vecs[i].exp_way});
        check($sformatf("v%0d_victim", i), {28'd0, v}, {28'd0, vecs[i].exp_vic});
        @(posedge clk); #1;
      end else begin
        do_fill(vecs[i].set, vecs[i].way, vecs[i].tag);
      end
    end

    // Fill and lookup together: write goes first, lookup next cycle
    fill_valid = 1'b1; fill_set = 6'd11; fill_way = 4'b0001; fill_tag = 19'h00042;
    lkp_valid = 1'b1; lkp_set = 6'd11; lkp_tag = 19'h00042;
    @(negedge clk);
    check("prio_write", {31'd0, tag_write_valid}, 32'd1);
    check("prio_no_read", {31'd0, tag_read_valid}, 32'd0);
    check("prio_lkp_ready", {31'd0, lkp_ready}, 32'd0);
    check("prio_fill_ready", {31'd0, fill_ready}, 32'd1);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    @(negedge clk);
    check("prio_read", {31'd0, tag_read_valid}, 32'd1);
    check("prio_lkp_ready2", {31'd0, lkp_ready}, 32'd1);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    @(negedge clk);
    check("prio_rsp_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("prio_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("prio_rsp_hit", {31'd0, rsp_hit}, 32'd1);
    check("prio_rsp_way", {28'd0, rsp_way}, 32'd1);
    @(posedge clk); #1;

    // Response backpressure: outputs hold while rsp_ready is low
    rsp_ready = 1'b0;
    do_lookup(6'd5, 19'h01234, h, w, v, lat);
    check("stall_latency", lat, 32'd2);
    lkp_valid = 1'b1; lkp_set = 6'd5; lkp_tag = 19'h01235;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_hit", {31'd0, rsp_hit}, 32'd1);
      check("stall_rsp_way", {28'd0, rsp_way}, 32'h4);
      check("stall_rsp_victim", {28'd0, rsp_victim}, 32'd0);
      check("stall_lkp_ready", {31'd0, lkp_ready}, 32'd0);
      check("stall_no_read", {31'd0, tag_read_valid}, 32'd0);
    end
    lkp_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_released", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-sweep at set 20
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    @(negedge clk);
    check("mid_sweep_set", {26'd0, tag_write_set}, 32'd20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_set", {26'd0, tag_write_set}, 32'd0);
    check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_set", {26'd0, tag_write_set}, 32'd0);
    check("restart_init_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    check("restart_set1", {26'd0, tag_write_set}, 32'd1);
    check("restart_write", {31'd0, tag_write_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
Requester side of the per-way tag SRAM interface: drives the tag array's read and write channels and consumes its per-way read response. It performs the post-reset invalidation sweep, set lookups with tag compare, hit-way and victim-way selection, and refill tag writes. It sits between the cache request pipeline and the tag array, one instance per cache.

Parameters:
WAY_NUM, 4, number of ways; one-hot way vectors are WAY_NUM bits wide.
SET_WIDTH, 6, set index width; the array has 2^SET_WIDTH sets.
TAG_WIDTH, 20, stored entry width; bit TAG_WIDTH-1 is the valid bit and the remaining bits are the address tag.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
init_done  out  1  high once the invalidation sweep has completed
lkp_valid  in  1  lookup request valid
lkp_ready  out  1  lookup request accepted when high with lkp_valid
lkp_set  in  SET_WIDTH  lookup set index
lkp_tag  in  TAG_WIDTH-1  lookup address tag
rsp_valid  out  1  lookup result valid
rsp_ready  in  1  lookup result consumed when high with rsp_valid
rsp_hit  out  1  lookup hit
rsp_way  out  WAY_NUM  one-hot hit way; 0 on miss
rsp_victim  out  WAY_NUM  one-hot victim way for refill; 0 on hit
fill_valid  in  1  refill tag-write request valid
fill_ready  out  1  refill request accepted
fill_set  in  SET_WIDTH  refill set index
fill_way  in  WAY_NUM  one-hot refill way
fill_tag  in  TAG_WIDTH-1  refill address tag
tag_read_valid  out  1  tag array read request
tag_read_ready  in  1  tag array read ready
tag_read_set  out  SET_WIDTH  read set index
tag_read_rsp  in  WAY_NUM x TAG_WIDTH  per-way read data; valid exactly 1 cycle after the read handshake
tag_write_valid  out  1  tag array write request
tag_write_ready  in  1  tag array write ready
tag_write_set  out  SET_WIDTH  write set index
tag_write_way_en  out  WAY_NUM  write way enables
tag_write_data  out  TAG_WIDTH  write entry

Behaviour:
- States: INIT, IDLE, CMP, RESP. Reset state is INIT.
- Reset values: init_done=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_victim=0, sweep counter=0, round-robin pointer=one-hot way 0.
- Reset asserted in any state returns the block to INIT asynchronously and restarts the sweep from set 0. Any in-flight lookup is dropped.
- INIT: drive tag_write_valid=1, tag_write_set=counter, way_en all ones, data all zeros.
  - Counter increments on each tag_write_ready.
  - After the write to set 2^SET_WIDTH-1 is accepted, go to IDLE and set init_done=1; it stays 1 until the next reset.
  - tag_read_valid, lkp_ready and fill_ready are 0 in INIT.
- IDLE: fill has priority over lookup.
  - When fill_valid: tag_write_valid=1, tag_write_set=fill_set, way_en=fill_way, data={1'b1, fill_tag}, fill_ready=tag_write_ready. Stay in IDLE.
  - When fill_valid is low: tag_read_valid=lkp_valid, tag_read_set=lkp_set, lkp_ready=tag_read_ready.
  - On the lookup handshake, register lkp_tag and go to CMP.
  - tag_read_valid and tag_write_valid are never high in the same cycle.
- A fill with fill_way=0 is accepted and writes no way.
- CMP (one cycle): each way hits if its entry valid bit is 1 and its tag field equals the registered tag.
  - Hit: rsp_hit=1, rsp_way=lowest-index hit way, rsp_victim=0.
  - Miss: rsp_hit=0, rsp_way=0. rsp_victim is the lowest-index invalid way if one exists, otherwise the round-robin pointer.
  - Result is registered; go to RESP with rsp_valid=1.
- Lookup latency: handshake in cycle N gives rsp_valid in cycle N+2.
- RESP: hold all rsp_* outputs stable until rsp_ready. On the rsp_valid and rsp_ready handshake: clear rsp_valid and go to IDLE.
  - If that response was a miss with all ways valid, rotate the pointer left by one, wrapping from way WAY_NUM-1 to way 0.
- fill_ready and lkp_ready are 0 in CMP and RESP; pending requests wait.
- Maximum lookup throughput is one per 3 cycles when rsp_ready is held high.

Test Plan:
- Reset, tag_write_ready=1 -> 64 consecutive all-way zero writes to sets 0..63, then init_done=1 in the following cycle, with no read issued.
- After init, lookup set 3 tag 0x1234 -> rsp_valid 2 cycles after accept, rsp_hit=0, rsp_victim=4'b0001.
- Fill set 5 way 4'b0100 tag 0x1234, then lookup set 5 tag 0x1234 -> tag_write_data=0x81234, rsp_hit=1, rsp_way=4'b0100; lookup of tag 0x1235 -> miss, rsp_victim=4'b0001.
- Fill all 4 ways of set 7, then three missing lookups to set 7 -> rsp_victim 4'b0001, 4'b0010, 4'b0100.
- fill_valid and lkp_valid high together in IDLE -> write issued first with tag_read_valid=0; lookup accepted the next cycle.
- rsp_ready held 0 for 5 cycles -> rsp_* outputs stable and lkp_ready=0; reset pulsed mid-sweep at set 20 -> sweep restarts at set 0 and init_done stays 0.
